// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates the register file write port between writeback and the MDU, tracking busy MDU destinations
module regfile_write_scheduler #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WbValid,
    input  logic [4:0]        WbReg,
    input  logic [DATA_W-1:0] WbData,
    input  logic              MdValid,
    output logic              MdReady,
    input  logic [4:0]        MdReg,
    input  logic [DATA_W-1:0] MdData,
    input  logic              ClaimValid,
    input  logic [4:0]        ClaimReg,
    input  logic [4:0]        IssueRs,
    input  logic [4:0]        IssueRt,
    input  logic [4:0]        IssueRd,
    input  logic              IssueRdValid,
    output logic              Stall,
    output logic              PipeHold,
    output logic              RegWrite,
    output logic [4:0]        WriteReg,
    output logic [DATA_W-1:0] WriteData
);
    logic [31:0] busy, busy_nxt;
    logic        src_md;
    logic [3:0]  cnt, cnt_nxt;

    assign MdReady = MdValid & ~WbValid;
    assign Stall   = busy[IssueRs] | busy[IssueRt] | (IssueRdValid & busy[IssueRd]) | (ClaimValid & busy[ClaimReg]);

    // a new claim on the same register overrides the clear of the completing write
    always_comb begin
        busy_nxt = busy;
        if (RegWrite && src_md) busy_nxt[WriteReg] = 1'b0;
        if (ClaimValid && !Stall) busy_nxt[ClaimReg] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign cnt_nxt = (MdValid && !MdReady) ? ((cnt == 4'hf) ? cnt : cnt + 4'd1) : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= 5'd0;
            WriteData <= '0;
            PipeHold  <= 1'b0;
            busy      <= '0;
            src_md    <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            RegWrite  <= WbValid ? (WbReg != 5'd0) : (MdReady && MdReg != 5'd0);
            WriteReg  <= WbValid ? WbReg : MdReady ? MdReg : WriteReg;
            WriteData <= WbValid ? WbData : MdReady ? MdData : WriteData;
            src_md    <= MdReady;
            busy      <= busy_nxt;
            cnt       <= cnt_nxt;
            PipeHold  <= (cnt_nxt == 4'(STARVE_LIMIT)) && (cnt != 4'(STARVE_LIMIT));
        end
    end
endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Schedules the single write port of the 32x32 register file between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). It keeps a busy scoreboard of registers with outstanding MDU results and raises Stall to the issue stage on RAW or WAW hazards. It sits between the writeback mux, the MDU and the register file write port (RegWrite/WriteReg/WriteData).

Parameters:
DATA_W, 32, data width of the write port
STARVE_LIMIT, 4, consecutive cycles an MDU result may wait before PipeHold is raised (1..15)

Ports:
clk  input  1  rising-edge clock, shared with the register file
rst_n  input  1  asynchronous active-low reset
WbValid  input  1  pipeline writeback request; cannot be back-pressured
WbReg  input  5  pipeline destination register
WbData  input  DATA_W  pipeline result
MdValid  input  1  MDU result valid
MdReady  output  1  MDU result accepted this cycle (valid&ready handshake)
MdReg  input  5  MDU destination register
MdData  input  DATA_W  MDU result
ClaimValid  input  1  issue stage dispatches an MDU op this cycle
ClaimReg  input  5  destination of the dispatched MDU op
IssueRs  input  5  source 1 of the instruction in issue
IssueRt  input  5  source 2 of the instruction in issue
IssueRd  input  5  destination of the instruction in issue
IssueRdValid  input  1  instruction in issue writes IssueRd
Stall  output  1  issue must hold (combinational)
PipeHold  output  1  pipeline must insert a writeback bubble next cycle
RegWrite  output  1  registered write enable to the register file
WriteReg  output  5  registered write address
WriteData  output  DATA_W  registered write data

Behaviour:
- Reset (async, rst_n low): RegWrite=0, WriteReg=0, WriteData=0, PipeHold=0, busy vector=0, starve counter=0. MdReady and Stall then evaluate from the cleared state. Any MDU result in flight is dropped. The MDU is reset by the same rst_n.
- Arbitration each cycle: WbValid has absolute priority. MdReady = MdValid & ~WbValid.
- Output stage: at posedge, if WbValid, load {WbReg,WbData}. Else if MdValid&MdReady, load {MdReg,MdData}. Otherwise RegWrite<=0. RegWrite<=1 only if the selected register is non-zero; writes to $0 are consumed with RegWrite=0.
- Latency: request at cycle N -> RegWrite high during cycle N+1 -> register file updated at the end of N+1.
- Scoreboard: busy[r] is set at the edge where ClaimValid&~Stall with ClaimReg=r!=0. busy[r] is cleared at the edge that ends the RegWrite cycle for an MDU-sourced write to r (tracked by a registered source flag). busy[0] is always 0. Set and clear of the same r on one edge: set wins.
- Stall = (busy[IssueRs] | busy[IssueRt]) | (IssueRdValid & busy[IssueRd]) | (ClaimValid & busy[ClaimReg]).
- Starvation: the counter increments each cycle with MdValid&~MdReady, and clears on an MDU accept or when MdValid is low. When the counter equals STARVE_LIMIT, PipeHold<=1 for one cycle. The pipeline guarantees WbValid=0 in the following cycle, so the MDU is granted. PipeHold returns to 0 after one cycle.
- Simultaneous WbValid and MdValid: WB is written, the MDU waits, and MdData/MdReg must be held stable by the MDU until accepted.
- WB to a busy register is impossible by construction (Stall). The block does not check for it.

Test Plan:
- Reset mid-write: WbValid=1, WbReg=5, WbData=0xDEADBEEF, rst_n pulsed low mid-cycle -> RegWrite=0, WriteData=0 immediately, busy cleared.
- Single WB: WbValid, WbReg=3, WbData=0x12345678 at cycle 0 -> cycle 1 RegWrite=1, WriteReg=3, WriteData=0x12345678; cycle 2 RegWrite=0.
- Collision: WbValid (reg 4, 0x11) and MdValid (reg 7, 0x22) in the same cycle -> MdReady=0; cycle 1 writes r4. Next cycle WbValid=0 -> MdReady=1; cycle 2 writes r7=0x22, and busy[7] clears at the end of cycle 2.
- Scoreboard RAW: ClaimValid, ClaimReg=9, then IssueRs=9 -> Stall=1 until the cycle after the MDU write of r9 completes, then Stall=0.
- Starvation with STARVE_LIMIT=4: MdValid held with WbValid=1 every cycle -> PipeHold=1 on the cycle after the 4th wait. Bench then drives WbValid=0 -> MdReady=1, the MDU result is written, and the counter resets.
- $0 handling: MDU result to reg 0 (0xFFFFFFFF) -> MdReady=1, RegWrite stays 0. ClaimReg=0 never sets busy, so IssueRs=0 never stalls.
